// File: rtl/multi_operand_adder_if.sv
// multi_operand_adder_if: start/operand/result bus between the adder controller and its host.
interface multi_operand_adder_if #(
  parameter int DATA_W  = 32,
  parameter int MAX_OPS = 4,
  parameter int ADDR_W  = 4
);
  localparam int CNT_W = $clog2(MAX_OPS + 1);
  logic              op_start;
  logic [CNT_W-1:0]  num_ops;
  logic [ADDR_W-1:0] dst_addr;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_read;
  logic              Register_we;
  logic [ADDR_W-1:0] reg_waddr;
  logic [DATA_W-1:0] out_result;
  logic              overflow;
  logic              op_busy;
  logic              op_done;
  modport master (
    output op_start, num_ops, dst_addr, fifo_empty, fifo_rdata,
    input  fifo_read, Register_we, reg_waddr, out_result, overflow, op_busy, op_done
  );
  modport slave (
    input  op_start, num_ops, dst_addr, fifo_empty, fifo_rdata,
    output fifo_read, Register_we, reg_waddr, out_result, overflow, op_busy, op_done
  );
endinterface

// File: rtl/multi_operand_adder.sv
// multi_operand_adder: pops n operands from a FIFO, sums them and writes the result to a register file.
module multi_operand_adder #(
  parameter int DATA_W  = 32,
  parameter int MAX_OPS = 4,
  parameter int ADDR_W  = 4
) (
  input logic clk,
  input logic reset,
  multi_operand_adder_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OPS + 1);
  typedef enum logic [1:0] {IDLE, EXEC, OUT, DONE} state_t;
  state_t            state;
  logic [CNT_W-1:0]  n, issued, received, n_req;
  logic              rd_valid, ov;
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W:0]   sum;
  assign n_req = bus.num_ops > CNT_W'(MAX_OPS) ? CNT_W'(MAX_OPS) : bus.num_ops;
  assign sum = {1'b0, acc} + {1'b0, bus.fifo_rdata};
  assign bus.fifo_read = state == EXEC && !bus.fifo_empty && issued < n;
  assign bus.Register_we = state == OUT;
  assign bus.op_done = state == DONE;
  assign bus.op_busy = state != IDLE;
  assign bus.out_result = acc;
  assign bus.overflow = ov;
  assign bus.reg_waddr = waddr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n <= '0;
      issued <= '0;
      received <= '0;
      rd_valid <= 1'b0;
      acc <= '0;
      ov <= 1'b0;
      waddr <= '0;
    end else begin
      rd_valid <= bus.fifo_read;
      case (state)
        IDLE: if (bus.op_start) begin
          n <= n_req;
          waddr <= bus.dst_addr;
          acc <= '0;
          ov <= 1'b0;
          issued <= '0;
          received <= '0;
          state <= n_req != '0 ? EXEC : DONE;
        end
        EXEC: begin
          if (bus.fifo_read) issued <= issued + 1'b1;
          // data lags its read strobe by one cycle, so completion keys off arrivals
          if (rd_valid) begin
            acc <= sum[DATA_W-1:0];
            ov <= ov | sum[DATA_W];
            received <= received + 1'b1;
            if (received == n - 1'b1) state <= OUT;
          end
        end
        OUT: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_operand_adder.sv
// tb_multi_operand_adder: directed scenarios against a small FIFO model with hand-computed sums.
module tb_multi_operand_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  multi_operand_adder_if #(.DATA_W(32), .MAX_OPS(4), .ADDR_W(4)) bus ();
  multi_operand_adder #(.DATA_W(32), .MAX_OPS(4), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [64];
  int wp = 0;
  int rp = 0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  int reads, we_cyc, done_cyc;
  logic [63:0] rmask, busy_mask;
  logic [31:0] res;
  logic [3:0] wa;
  logic ov;
  assign bus.fifo_empty = (rp == wp) || stall;
  always @(posedge clk)
    if (flush) rp <= wp;
    else if (bus.fifo_read) begin
      bus.fifo_rdata <= mem[rp[5:0]];
      rp <= rp + 1;
    end
  task automatic push(input logic [31:0] v);
    mem[wp[5:0]] = v;
    wp++;
  endtask
  task automatic drain();
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
  endtask
  task automatic run(input int nops, input int addr, input int st_after, input int st_len, input int ic, input int rc);
    @(negedge clk);
    bus.op_start = 1'b1;
    bus.num_ops = 3'(nops);
    bus.dst_addr = 4'(addr);
    reads = 0; we_cyc = 0; done_cyc = 0; rmask = '0; busy_mask = '0; res = 'x; wa = 'x; ov = 1'bx;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      bus.op_start = (c == ic);
      if (c == ic) bus.dst_addr = 4'd12;
      stall = (c > st_after && c <= st_after + st_len);
      reset = (c == rc);
      @(negedge clk);
      if (bus.fifo_read) begin
        reads++;
        rmask[c] = 1'b1;
      end
      busy_mask[c] = bus.op_busy;
      if (bus.Register_we) begin
        we_cyc = c; res = bus.out_result; wa = bus.reg_waddr; ov = bus.overflow;
      end
      if (bus.op_done) begin
        done_cyc = c;
        break;
      end
    end
    bus.op_start = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    bus.op_start = 1'b1; bus.num_ops = 3'd3; bus.dst_addr = 4'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.fifo_read, bus.Register_we, bus.op_done, bus.op_busy, bus.overflow} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {bus.fifo_read, bus.Register_we, bus.op_done, bus.op_busy, bus.overflow});
    end
    checks++;
    if (bus.out_result !== 32'd0 || bus.reg_waddr !== 4'd0) begin
      errors++; $display("FAIL reset_regs: got result %0h addr %0d want 0 0", bus.out_result, bus.reg_waddr);
    end
    reset = 1'b0; bus.op_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.op_busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: got busy %b want 0", bus.op_busy);
    end
  endtask
  task automatic test_basic_sum();
    push(10); push(20); push(30);
    run(3, 5, 0, 0, 0, 0);
    checks++;
    if (rmask !== 64'hE) begin errors++; $display("FAIL basic_reads: got %h want e", rmask); end
    checks++;
    if (we_cyc !== 5 || res !== 32'd60 || wa !== 4'd5 || ov !== 1'b0) begin
      errors++; $display("FAIL basic_write: got cyc %0d res %0d addr %0d ov %b want 5 60 5 0", we_cyc, res, wa, ov);
    end
    checks++;
    if (done_cyc !== 6) begin errors++; $display("FAIL basic_done: got %0d want 6", done_cyc); end
    @(negedge clk);
    checks++;
    if (bus.op_busy !== 1'b0 || bus.out_result !== 32'd60) begin
      errors++; $display("FAIL basic_hold: got busy %b res %0d want 0 60", bus.op_busy, bus.out_result);
    end
  endtask
  task automatic test_overflow();
    push(32'hFFFF_FFFF); push(32'h2);
    run(2, 3, 0, 0, 0, 0);
    checks++;
    if (res !== 32'h1 || ov !== 1'b1 || we_cyc !== 4) begin
      errors++; $display("FAIL ovf_set: got res %h ov %b cyc %0d want 1 1 4", res, ov, we_cyc);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    push(1); push(1);
    run(2, 3, 0, 0, 0, 0);
    checks++;
    if (res !== 32'd2 || ov !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got res %0d ov %b want 2 0", res, ov);
    end
  endtask
  task automatic test_empty_stall();
    push(1); push(2); push(3); push(4);
    run(4, 7, 2, 2, 0, 0);
    checks++;
    if (reads !== 4 || rmask !== 64'h66) begin
      errors++; $display("FAIL stall_reads: got %0d mask %h want 4 66", reads, rmask);
    end
    checks++;
    if (done_cyc !== 9 || res !== 32'd10 || wa !== 4'd7) begin
      errors++; $display("FAIL stall_done: got cyc %0d res %0d addr %0d want 9 10 7", done_cyc, res, wa);
    end
  endtask
  task automatic test_count_corners();
    run(0, 2, 0, 0, 0, 0);
    checks++;
    if (reads !== 0 || we_cyc !== 0 || done_cyc !== 1) begin
      errors++; $display("FAIL zero_ops: got reads %0d we %0d done %0d want 0 0 1", reads, we_cyc, done_cyc);
    end
    push(1); push(2); push(3); push(4); push(100);
    run(7, 8, 0, 0, 0, 0);
    checks++;
    if (reads !== 4 || res !== 32'd10 || done_cyc !== 7) begin
      errors++; $display("FAIL clamp_ops: got reads %0d res %0d done %0d want 4 10 7", reads, res, done_cyc);
    end
    checks++;
    if (wp - rp !== 1) begin errors++; $display("FAIL clamp_left: got %0d want 1", wp - rp); end
    drain();
  endtask
  task automatic test_interference();
    push(5); push(6); push(7); push(8);
    run(4, 3, 0, 0, 2, 0);
    checks++;
    if (wa !== 4'd3 || res !== 32'd26 || done_cyc !== 7) begin
      errors++; $display("FAIL start_ignored: got addr %0d res %0d done %0d want 3 26 7", wa, res, done_cyc);
    end
    push(1); push(2); push(3); push(4);
    run(4, 6, 0, 0, 0, 2);
    checks++;
    if (we_cyc !== 0 || done_cyc !== 0 || busy_mask[3] !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got we %0d done %0d busy3 %b want 0 0 0", we_cyc, done_cyc, busy_mask[3]);
    end
    checks++;
    if (bus.out_result !== 32'd0 || bus.reg_waddr !== 4'd0) begin
      errors++; $display("FAIL mid_reset_regs: got res %0d addr %0d want 0 0", bus.out_result, bus.reg_waddr);
    end
    drain();
    push(7); push(8);
    run(2, 9, 0, 0, 0, 0);
    checks++;
    if (res !== 32'd15 || wa !== 4'd9 || we_cyc !== 4 || done_cyc !== 5) begin
      errors++; $display("FAIL after_reset: got res %0d addr %0d we %0d done %0d want 15 9 4 5", res, wa, we_cyc, done_cyc);
    end
  endtask
  initial begin
    test_reset();
    test_basic_sum();
    test_overflow();
    test_empty_stall();
    test_count_corners();
    test_interference();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
